wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters.
- Primary requester: the pipeline writeback stage (reg_wr_en / wr_data / destination_RNS path).
- Secondary requester: a multi-cycle producer such as an IO read completion or an RNS converter. Its writes are buffered in a small FIFO and drained into cycles the pipeline leaves idle.
- A wait counter bounds secondary latency. When the counter expires, the block stalls the pipeline for one cycle to force a drain.

Parameters:
- NUM_DOMAINS, 1, number of 8-bit residue domains; data width is NUM_DOMAINS*8.
- REG_ADDR_WID, 4, register-file address width.
- FIFO_DEPTH, 4, secondary FIFO entries; power of 2, at least 2.
- MAX_WAIT, 8, cycles a non-empty FIFO head may go ungranted before stall_pl asserts; at least 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- pl_wr_en  in  1  pipeline write request (already qualified by invalidate).
- pl_wr_rns  in  1  pipeline destination is RNS register file.
- pl_wr_addr  in  REG_ADDR_WID  pipeline destination register.
- pl_wr_data  in  NUM_DOMAINS*8  pipeline write data, {Domain1, Domain2, ...}.
- stall_pl  out  1  pipeline must hold its current writeback and re-present it next cycle.
- sec_valid  in  1  secondary write offered.
- sec_ready  out  1  FIFO can accept this cycle.
- sec_rns  in  1  secondary destination is RNS register file.
- sec_addr  in  REG_ADDR_WID  secondary destination register.
- sec_data  in  NUM_DOMAINS*8  secondary write data.
- rf_wr_en  out  1  registered register-file write enable.
- rf_wr_rns  out  1  registered RNS/normal file select.
- rf_wr_addr  out  REG_ADDR_WID  registered write address.
- rf_wr_data  out  NUM_DOMAINS*8  registered write data.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset (reset==0 at posedge):
- rf_wr_en, rf_wr_rns, rf_wr_addr and rf_wr_data go to 0.
- fifo_count goes to 0, wait_cnt goes to 0, FIFO pointers go to 0.
- Reset mid-operation discards all queued entries; no write is issued on that edge.
- sec_ready is 0 while reset==0, regardless of count.

Combinational outputs:
- sec_ready = (fifo_count != FIFO_DEPTH).
- stall_pl = (fifo_count != 0) && (wait_cnt == MAX_WAIT).

Grant, evaluated each cycle with priority top to bottom:
1. stall_pl==1: grant the FIFO head. The pipeline write is ignored this cycle and the pipeline holds it.
2. pl_wr_en==1: grant the pipeline.
3. fifo_count!=0: grant the FIFO head.
4. Otherwise: idle.

Output register:
- Selected request is latched into rf_wr_* at posedge, so latency is 1 cycle from grant to rf_wr_en.
- rf_wr_en is 0 on idle cycles; the other rf_wr_* fields then hold their previous value.

FIFO:
- Push when sec_valid && sec_ready; pop when the head is granted.
- Simultaneous push and pop: count is unchanged, and a push is legal even at full only if it is not refused by sec_ready. sec_ready uses the pre-pop count, so full refuses the push.
- No bypass: an entry pushed into an empty FIFO is grantable the next cycle at the earliest.
- Pointers wrap modulo FIFO_DEPTH.

wait_cnt:
- Cleared on a head grant or when the FIFO is empty.
- Otherwise incremented while the FIFO is non-empty and the head is not granted.
- Saturates at MAX_WAIT.

Ordering and interlocks:
- Ordering between pipeline and secondary writes to the same address is not enforced. Software and the issuing unit own that hazard.
- Entries within the FIFO drain in order.
- The arbiter never drops a write. Every accepted push appears exactly once on rf_wr_*.

Decomposition:
- Package wb_arb_pkg holds:
  - the write-request struct {rns, addr, data};
  - the GRANT_NONE/GRANT_PL/GRANT_SEC encoding;
  - a clog2 helper.
- One sub-module, wb_sec_fifo: synchronous FIFO with count output, parameterised on width and depth.
- The arbiter holds the grant logic, wait_cnt and the output register.

Test Plan:
- Reset: drive reset=0 for 2 cycles with sec_valid=1 and pl_wr_en=1 → rf_wr_en=0, fifo_count=0, sec_ready=0. After release, sec_ready=1.
- Idle-slot drain: pl_wr_en=0; push sec addr=3, data=8'hA5 at cycle t → rf_wr_en=1, addr=3, data=A5 at t+2, and fifo_count returns to 0.
- Pipeline priority: pl_wr_en=1 continuously (addr=1, data=8'h11) while pushing 4 secondary entries → the FIFO fills and sec_ready=0 at count 4. A fifth push is refused. Pipeline writes appear every cycle until stall_pl.
- Starvation bound: MAX_WAIT=8 with pl_wr_en held 1 and the FIFO non-empty → stall_pl asserts in the 9th cycle after the first push. That cycle's rf write is the FIFO head and wait_cnt clears. The held pipeline write (addr=1) is issued the next cycle.
- Full with simultaneous pop: count=4 and the head granted while sec_valid=1 → the push is refused and count goes to 3. On the next cycle the push is accepted and the FIFO order of all data is preserved.
- Reset mid-drain: 3 entries queued, reset=0 for 1 cycle → no further secondary writes appear and fifo_count=0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
//   wb_req_t : one register-file write {rns, addr, data} at the default configuration
//   grant_e  : which requester owns the write port this cycle
//   clog2    : ceiling log2 for sizing counters and pointers
package wb_arb_pkg;

    localparam int unsigned WB_ADDR_W = 4;
    localparam int unsigned WB_DATA_W = 8;

    typedef struct packed {
        logic                 rns;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PL   = 2'd1,
        GRANT_SEC  = 2'd2
    } grant_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_sec_fifo.sv
// Synchronous FIFO with occupancy count for buffered secondary writes.
//   clk, reset   : clock, synchronous active-low reset (clears pointers and count)
//   push, wdata  : write an entry (caller never pushes when full)
//   pop, rdata   : rdata is the current head; pop advances it (caller never pops when empty)
//   count        : current occupancy, 0..DEPTH
module wb_sec_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline writeback stage and a
// FIFO-buffered secondary producer. The pipeline wins by default; the FIFO drains
// into idle slots, and a wait counter forces a one-cycle pipeline stall so the
// FIFO head is never starved for more than MAX_WAIT cycles.
//   clk, reset                : clock, synchronous active-low reset
//   pl_wr_*                   : pipeline write request
//   stall_pl                  : pipeline must hold and re-present its writeback
//   sec_valid/sec_ready/sec_* : secondary write handshake into the FIFO
//   rf_wr_*                   : registered register-file write port
//   fifo_count                : secondary FIFO occupancy
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS  = 1,
    parameter int unsigned REG_ADDR_WID = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MAX_WAIT     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pl_wr_en,
    input  logic                          pl_wr_rns,
    input  logic [REG_ADDR_WID-1:0]       pl_wr_addr,
    input  logic [NUM_DOMAINS*8-1:0]      pl_wr_data,
    output logic                          stall_pl,
    input  logic                          sec_valid,
    output logic                          sec_ready,
    input  logic                          sec_rns,
    input  logic [REG_ADDR_WID-1:0]       sec_addr,
    input  logic [NUM_DOMAINS*8-1:0]      sec_data,
    output logic                          rf_wr_en,
    output logic                          rf_wr_rns,
    output logic [REG_ADDR_WID-1:0]       rf_wr_addr,
    output logic [NUM_DOMAINS*8-1:0]      rf_wr_data,
    output logic [clog2(FIFO_DEPTH):0]    fifo_count
);

    localparam int unsigned DATA_W = NUM_DOMAINS * 8;
    localparam int unsigned CNT_W  = clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WAIT_W = clog2(MAX_WAIT + 1);

    // Same layout as wb_req_t, sized by this instance's parameters.
    typedef struct packed {
        logic                    rns;
        logic [REG_ADDR_WID-1:0] addr;
        logic [DATA_W-1:0]       data;
    } req_t;

    req_t              sec_req;
    req_t              head;
    grant_e            grant_c;
    logic              push_c;
    logic              pop_c;
    logic              fifo_empty_c;
    logic [WAIT_W-1:0] wait_cnt;

    assign sec_req      = '{rns: sec_rns, addr: sec_addr, data: sec_data};
    assign fifo_empty_c = (fifo_count == '0);

    // Ready uses the pre-pop count, so a full FIFO refuses even when its head drains.
    assign sec_ready = reset && (fifo_count != CNT_W'(FIFO_DEPTH));
    assign stall_pl  = !fifo_empty_c && (wait_cnt == WAIT_W'(MAX_WAIT));
    assign push_c    = sec_valid && sec_ready;
    assign pop_c     = (grant_c == GRANT_SEC);

    wb_sec_fifo #(
        .WIDTH (1 + REG_ADDR_WID + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (sec_req),
        .rdata (head),
        .count (fifo_count)
    );

    // Grant priority: forced drain, then pipeline, then opportunistic drain.
    always_comb begin
        grant_c = GRANT_NONE;
        if (stall_pl) begin
            grant_c = GRANT_SEC;
        end else if (pl_wr_en) begin
            grant_c = GRANT_PL;
        end else if (!fifo_empty_c) begin
            grant_c = GRANT_SEC;
        end
    end

    // Cycles the current head has waited without a grant, saturating.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (pop_c || fifo_empty_c) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Write-port register; payload fields hold on idle cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_wr_en   <= 1'b0;
            rf_wr_rns  <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else begin
            rf_wr_en <= (grant_c != GRANT_NONE);
            case (grant_c)
                GRANT_PL: begin
                    rf_wr_rns  <= pl_wr_rns;
                    rf_wr_addr <= pl_wr_addr;
                    rf_wr_data <= pl_wr_data;
                end
                GRANT_SEC: begin
                    rf_wr_rns  <= head.rns;
                    rf_wr_addr <= head.addr;
                    rf_wr_data <= head.data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a queue-based reference model and
// an expected-write scoreboard.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXW  = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pl_wr_en = 1'b0;
    logic          pl_wr_rns = 1'b0;
    logic [AW-1:0] pl_wr_addr = '0;
    logic [DW-1:0] pl_wr_data = '0;
    logic          stall_pl;
    logic          sec_valid = 1'b0;
    logic          sec_ready;
    logic          sec_rns = 1'b0;
    logic [AW-1:0] sec_addr = '0;
    logic [DW-1:0] sec_data = '0;
    logic          rf_wr_en;
    logic          rf_wr_rns;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic [2:0]    fifo_count;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .NUM_DOMAINS  (1),
        .REG_ADDR_WID (AW),
        .FIFO_DEPTH   (DEPTH),
        .MAX_WAIT     (MAXW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pl_wr_en   (pl_wr_en),
        .pl_wr_rns  (pl_wr_rns),
        .pl_wr_addr (pl_wr_addr),
        .pl_wr_data (pl_wr_data),
        .stall_pl   (stall_pl),
        .sec_valid  (sec_valid),
        .sec_ready  (sec_ready),
        .sec_rns    (sec_rns),
        .sec_addr   (sec_addr),
        .sec_data   (sec_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_rns  (rf_wr_rns),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .fifo_count (fifo_count)
    );

    typedef struct packed {
        logic    en;
        wb_req_t req;
    } exp_t;

    exp_t    exp_q[$];
    wb_req_t mq[$];
    int      mwait = 0;
    wb_req_t m_rf = '0;
    int      checks = 0;
    int      errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_pl(input logic en, input logic rns, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_wr_en   = en;
        pl_wr_rns  = rns;
        pl_wr_addr = a;
        pl_wr_data = d;
    endtask

    task automatic set_sec(input logic v, input logic rns, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sec_valid = v;
        sec_rns   = rns;
        sec_addr  = a;
        sec_data  = d;
    endtask

    // One clock: check handshake outputs, predict the write, advance, compare.
    task automatic cycle(input string tag);
        exp_t e;
        int   n;
        logic exp_ready;
        logic exp_stall;
        logic pop;
        #1;
        n         = mq.size();
        exp_ready = reset && (n != int'(DEPTH));
        exp_stall = (n != 0) && (mwait == int'(MAXW));
        chk({tag, ":sec_ready"}, 32'(sec_ready), 32'(exp_ready));
        chk({tag, ":stall_pl"},  32'(stall_pl),  32'(exp_stall));
        e.en  = 1'b0;
        e.req = m_rf;
        pop   = 1'b0;
        if (!reset) begin
            e.req = '0;
        end else if (exp_stall || (!pl_wr_en && n != 0)) begin
            pop   = 1'b1;
            e.en  = 1'b1;
            e.req = mq[0];
        end else if (pl_wr_en) begin
            e.en  = 1'b1;
            e.req = '{rns: pl_wr_rns, addr: pl_wr_addr, data: pl_wr_data};
        end
        exp_q.push_back(e);
        if (!reset) begin
            mq.delete();
            mwait = 0;
        end else begin
            if (pop || n == 0) mwait = 0;
            else if (mwait < int'(MAXW)) mwait++;
            if (pop) void'(mq.pop_front());
            if (sec_valid && exp_ready) mq.push_back('{rns: sec_rns, addr: sec_addr, data: sec_data});
        end
        m_rf = e.req;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ":rf_wr_en"},   32'(rf_wr_en),   32'(e.en));
        chk({tag, ":rf_wr_rns"},  32'(rf_wr_rns),  32'(e.req.rns));
        chk({tag, ":rf_wr_addr"}, 32'(rf_wr_addr), 32'(e.req.addr));
        chk({tag, ":rf_wr_data"}, 32'(rf_wr_data), 32'(e.req.data));
        chk({tag, ":fifo_count"}, 32'(fifo_count), 32'(mq.size()));
    endtask

    initial begin
        int stall_at;

        // Reset held with both requesters active.
        set_pl(1'b1, 1'b0, 4'd1, 8'h11);
        set_sec(1'b1, 1'b0, 4'd2, 8'h22);
        @(posedge clk);
        #1;
        cycle("rst0");
        cycle("rst1");
        chk("rst:rf_wr_en", 32'(rf_wr_en), 32'd0);
        chk("rst:fifo_count", 32'(fifo_count), 32'd0);
        chk("rst:sec_ready", 32'(sec_ready), 32'd0);
        reset = 1'b1;
        set_pl(1'b0, 1'b0, 4'd0, 8'h00);
        set_sec(1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        chk("rel:sec_ready", 32'(sec_ready), 32'd1);
        cycle("idle");

        // Idle-slot drain: write appears two edges after the push cycle.
        set_sec(1'b1, 1'b1, 4'd3, 8'hA5);
        cycle("drain_push");
        set_sec(1'b0, 1'b0, 4'd0, 8'h00);
        cycle("drain_pop");
        chk("drain:en", 32'(rf_wr_en), 32'd1);
        chk("drain:addr", 32'(rf_wr_addr), 32'd3);
        chk("drain:data", 32'(rf_wr_data), 32'hA5);
        chk("drain:count", 32'(fifo_count), 32'd0);

        // Pipeline priority, fill, starvation stall, full with simultaneous pop.
        set_pl(1'b1, 1'b0, 4'd1, 8'h11);
        for (int i = 0; i < 4; i++) begin
            set_sec(1'b1, 1'b1, 4'(5 + i), 8'(8'h21 + i));
            cycle("fill");
        end
        set_sec(1'b1, 1'b1, 4'd9, 8'h25);
        #1;
        chk("full:sec_ready", 32'(sec_ready), 32'd0);
        chk("full:count", 32'(fifo_count), 32'd4);
        stall_at = 0;
        for (int i = 4; i < 20; i++) begin
            if (stall_pl) begin
                stall_at = i;
                break;
            end
            cycle("starve");
        end
        chk("starve:stall_cycle", 32'(stall_at), 32'd9);
        chk("stall:sec_ready", 32'(sec_ready), 32'd0);
        cycle("stall");
        chk("stall:head_addr", 32'(rf_wr_addr), 32'd5);
        chk("stall:head_data", 32'(rf_wr_data), 32'h21);
        chk("stall:count", 32'(fifo_count), 32'd3);
        cycle("held_pl");
        chk("held:addr", 32'(rf_wr_addr), 32'd1);
        chk("held:count", 32'(fifo_count), 32'd4);
        set_sec(1'b0, 1'b0, 4'd0, 8'h00);
        set_pl(1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 6; i++) cycle("order");
        chk("order:empty", 32'(fifo_count), 32'd0);

        // Reset mid-drain discards queued entries.
        set_pl(1'b1, 1'b1, 4'd1, 8'h11);
        for (int i = 0; i < 3; i++) begin
            set_sec(1'b1, 1'b0, 4'(10 + i), 8'(8'h31 + i));
            cycle("q3");
        end
        set_sec(1'b0, 1'b0, 4'd0, 8'h00);
        chk("q3:count", 32'(fifo_count), 32'd3);
        reset = 1'b0;
        cycle("midrst");
        reset = 1'b1;
        set_pl(1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 4; i++) cycle("post_rst");
        chk("post_rst:en", 32'(rf_wr_en), 32'd0);
        chk("post_rst:count", 32'(fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
